// File: rtl/dmem_pkg.sv
// dmem_pkg: shared size encodings, FSM states and error check for the data-memory controller
package dmem_pkg;
   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_X = 2'b11;
   localparam int MEM_WORDS_DEF = 256;
   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;
   function automatic logic access_err(logic [1:0] size, logic [31:0] addr, int words);
      return (size == SZ_X) || (size == SZ_H && addr[0]) ||
             (size == SZ_W && addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(words));
   endfunction
endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: big-endian lane extraction with extension for loads, lane merge for sub-word stores
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        zext,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged
);
   logic [4:0]  bshift;
   logic [4:0]  hshift;
   logic [7:0]  bsel;
   logic [15:0] hsel;
   logic [31:0] bmask;
   logic [31:0] hmask;
   // offset 0 is the most significant lane, so shifts count down from the top
   always_comb begin
      bshift    = {~offset, 3'b000};
      hshift    = {~offset[1], 4'b0000};
      bsel      = 8'(rdata >> bshift);
      hsel      = 16'(rdata >> hshift);
      bmask     = 32'h0000_00ff << bshift;
      hmask     = 32'h0000_ffff << hshift;
      load_data = size == SZ_W ? rdata :
                  size == SZ_H ? (zext ? {16'h0000, hsel} : {{16{hsel[15]}}, hsel}) :
                                 (zext ? {24'h000000, bsel} : {{24{bsel[7]}}, bsel});
      merged    = size == SZ_W ? wdata :
                  size == SZ_H ? ((rdata & ~hmask) | (32'(wdata[15:0]) << hshift)) :
                                 ((rdata & ~bmask) | (32'(wdata[7:0]) << bshift));
   end
endmodule

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: CPU load/store front end driving a word-indexed synchronous data memory
module dmem_access_ctrl
   import dmem_pkg::*;
#(
   parameter int MEM_WORDS = MEM_WORDS_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_addr,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);
   state_t      state;
   state_t      next_state;
   logic        accept;
   logic        we_q;
   logic        uns_q;
   logic        err_q;
   logic [1:0]  size_q;
   logic [1:0]  off_q;
   logic [31:0] rdata_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] load_data;
   logic [31:0] merged;

   assign accept    = req_valid && req_ready;
   assign rsp_err   = rsp_valid && err_q;
   assign rsp_rdata = rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   dmem_lane_align u_align (
      .rdata     (mem_rdata),
      .offset    (off_q),
      .size      (size_q),
      .zext      (uns_q),
      .wdata     (wdata_q),
      .load_data (load_data),
      .merged    (merged)
   );

   // state register; reset aborts any access in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // next state and memory strobes; strobes depend only on state so reset drops them at once
   always_comb begin
      next_state = state;
      req_ready  = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      rsp_valid  = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid)
               next_state = access_err(req_size, req_addr, MEM_WORDS) ? RESP :
                            (req_we && req_size == SZ_W) ? WR : RD;
         end
         RD: begin
            mem_read   = 1'b1;
            next_state = CAP;
         end
         CAP:  next_state = we_q ? WR : RESP;
         WR: begin
            mem_write  = 1'b1;
            next_state = RESP;
         end
         RESP: begin
            rsp_valid  = 1'b1;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // request latch at accept; CAP captures either the load result or the merged store word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q    <= 1'b0;
         uns_q   <= 1'b0;
         err_q   <= 1'b0;
         size_q  <= SZ_B;
         off_q   <= 2'b00;
         rdata_q <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else if (accept) begin
         we_q    <= req_we;
         uns_q   <= req_unsigned;
         err_q   <= access_err(req_size, req_addr, MEM_WORDS);
         size_q  <= req_size;
         off_q   <= req_addr[1:0];
         rdata_q <= '0;
         addr_q  <= {2'b00, req_addr[31:2]};
         wdata_q <= req_wdata;
      end else if (state == CAP) begin
         if (we_q) wdata_q <= merged;
         else      rdata_q <= load_data;
      end
   end
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb_dmem_access_ctrl: directed vector bench with a synchronous word memory model
module tb_dmem_access_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_addr;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic [31:0] mem [256];
   int          checks = 0;
   int          errors = 0;

   typedef struct {
      logic        we;
      logic [1:0]  sz;
      logic        uns;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        err;
      int          lat;
      logic [31:0] mwd;
   } vec_t;

   vec_t vecs [27];

   dmem_access_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .mem_addr     (mem_addr),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata)
   );

   always #5 clk = ~clk;

   // synchronous data memory: read data appears the cycle after mem_read
   always @(posedge clk) begin
      if (mem_read) mem_rdata <= mem[mem_addr[7:0]];
      if (mem_write) mem[mem_addr[7:0]] <= mem_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run(input vec_t v, input int idx);
      int          lat = 0;
      logic        rd_seen = 1'b0;
      logic        wr_seen = 1'b0;
      logic        err_s = 1'b0;
      logic [31:0] rdat = '0;
      logic [31:0] maddr = '0;
      logic [31:0] mwd = '0;
      logic        exp_rd;
      logic        exp_wr;
      exp_rd = !v.err && (!v.we || v.sz != 2'b10);
      exp_wr = !v.err && v.we;
      @(negedge clk);
      chk($sformatf("v%0d ready", idx), {31'b0, req_ready}, 32'd1);
      req_valid = 1'b1;
      req_we = v.we;
      req_size = v.sz;
      req_unsigned = v.uns;
      req_addr = v.addr;
      req_wdata = v.wd;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      req_we = ~v.we;
      req_size = ~v.sz;
      req_unsigned = ~v.uns;
      req_addr = ~v.addr;
      req_wdata = ~v.wd;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         @(negedge clk);
         chk($sformatf("v%0d rd_wr_excl", idx), {31'b0, mem_read & mem_write}, 32'd0);
         if ((mem_read || mem_write) && !(rd_seen || wr_seen)) maddr = mem_addr;
         if (mem_read) rd_seen = 1'b1;
         if (mem_write) begin
            wr_seen = 1'b1;
            mwd = mem_wdata;
         end
         if (rsp_valid) begin
            lat = c;
            rdat = rsp_rdata;
            err_s = rsp_err;
         end
      end
      chk($sformatf("v%0d latency", idx), lat, v.lat);
      chk($sformatf("v%0d rdata", idx), rdat, v.rd);
      chk($sformatf("v%0d err", idx), {31'b0, err_s}, {31'b0, v.err});
      chk($sformatf("v%0d mem_read_seen", idx), {31'b0, rd_seen}, {31'b0, exp_rd});
      chk($sformatf("v%0d mem_write_seen", idx), {31'b0, wr_seen}, {31'b0, exp_wr});
      if (exp_rd || exp_wr) chk($sformatf("v%0d mem_addr", idx), maddr, {2'b00, v.addr[31:2]});
      if (exp_wr) chk($sformatf("v%0d mem_wdata", idx), mwd, v.mwd);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      mem[3] = 32'd10;
      mem[4] = 32'd5000;
      mem[5] = 32'd100000;
      //           we  sz     uns  addr          wdata         rdata         err  lat mem_wdata
      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h10,  32'h0,         32'h0000_1388, 1'b0, 3, 32'h0};
      vecs[1]  = '{1'b0, 2'b00, 1'b0, 32'h13,  32'h0,         32'hFFFF_FF88, 1'b0, 3, 32'h0};
      vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13,  32'h0,         32'h0000_0088, 1'b0, 3, 32'h0};
      vecs[3]  = '{1'b0, 2'b01, 1'b0, 32'h16,  32'h0,         32'hFFFF_86A0, 1'b0, 3, 32'h0};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h16,  32'h0,         32'h0000_86A0, 1'b0, 3, 32'h0};
      vecs[5]  = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,         32'h0001_86A0, 1'b0, 3, 32'h0};
      vecs[6]  = '{1'b0, 2'b00, 1'b0, 32'h10,  32'h0,         32'h0000_0000, 1'b0, 3, 32'h0};
      vecs[7]  = '{1'b0, 2'b00, 1'b1, 32'h12,  32'h0,         32'h0000_0013, 1'b0, 3, 32'h0};
      vecs[8]  = '{1'b1, 2'b00, 1'b0, 32'h0C,  32'h0000_00AB, 32'h0,         1'b0, 4, 32'hAB00_000A};
      vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0C,  32'h0,         32'hAB00_000A, 1'b0, 3, 32'h0};
      vecs[10] = '{1'b1, 2'b10, 1'b0, 32'h14,  32'hDEAD_BEEF, 32'h0,         1'b0, 2, 32'hDEAD_BEEF};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h14,  32'h0,         32'hDEAD_BEEF, 1'b0, 3, 32'h0};
      vecs[12] = '{1'b0, 2'b00, 1'b0, 32'h15,  32'h0,         32'hFFFF_FFAD, 1'b0, 3, 32'h0};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h14,  32'h0,         32'hFFFF_DEAD, 1'b0, 3, 32'h0};
      vecs[14] = '{1'b0, 2'b01, 1'b1, 32'h14,  32'h0,         32'h0000_DEAD, 1'b0, 3, 32'h0};
      vecs[15] = '{1'b1, 2'b01, 1'b0, 32'h16,  32'hFFFF_1234, 32'h0,         1'b0, 4, 32'hDEAD_1234};
      vecs[16] = '{1'b1, 2'b00, 1'b1, 32'h17,  32'hFFFF_FF5A, 32'h0,         1'b0, 4, 32'hDEAD_125A};
      vecs[17] = '{1'b0, 2'b10, 1'b1, 32'h14,  32'h0,         32'hDEAD_125A, 1'b0, 3, 32'h0};
      vecs[18] = '{1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0,         32'h0,         1'b0, 3, 32'h0};
      vecs[19] = '{1'b0, 2'b10, 1'b0, 32'h0E,  32'h0,         32'h0,         1'b1, 1, 32'h0};
      vecs[20] = '{1'b0, 2'b01, 1'b0, 32'h11,  32'h0,         32'h0,         1'b1, 1, 32'h0};
      vecs[21] = '{1'b0, 2'b11, 1'b0, 32'h10,  32'h0,         32'h0,         1'b1, 1, 32'h0};
      vecs[22] = '{1'b0, 2'b10, 1'b0, 32'h400, 32'h0,         32'h0,         1'b1, 1, 32'h0};
      vecs[23] = '{1'b1, 2'b00, 1'b0, 32'h400, 32'h0000_0077, 32'h0,         1'b1, 1, 32'h0};
      vecs[24] = '{1'b1, 2'b10, 1'b0, 32'h12,  32'h1111_1111, 32'h0,         1'b1, 1, 32'h0};
      vecs[25] = '{1'b0, 2'b01, 1'b1, 32'h0E,  32'h0,         32'h0000_000A, 1'b0, 3, 32'h0};
      vecs[26] = '{1'b0, 2'b00, 1'b0, 32'h0C,  32'h0,         32'hFFFF_FFAB, 1'b0, 3, 32'h0};
      repeat (2) @(negedge clk);
      chk("reset req_ready", {31'b0, req_ready}, 32'd1);
      chk("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("reset rsp_err", {31'b0, rsp_err}, 32'd0);
      chk("reset mem_read", {31'b0, mem_read}, 32'd0);
      chk("reset mem_write", {31'b0, mem_write}, 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'd0);
      chk("reset mem_addr", mem_addr, 32'd0);
      chk("reset mem_wdata", mem_wdata, 32'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 27; i++) run(vecs[i], i);
      // sub-word store aborted by reset during CAP: no write, no response
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b01;
      req_addr = 32'h0C;
      req_wdata = 32'h0000_1234;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_cap RD mem_read", {31'b0, mem_read}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("abort_cap mem_read drop", {31'b0, mem_read}, 32'd0);
      chk("abort_cap mem_write", {31'b0, mem_write}, 32'd0);
      chk("abort_cap req_ready", {31'b0, req_ready}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_cap hold mem_write", {31'b0, mem_write}, 32'd0);
         chk("abort_cap hold rsp_valid", {31'b0, rsp_valid}, 32'd0);
      end
      rst_n = 1'b1;
      @(negedge clk);
      chk("abort_cap ready after release", {31'b0, req_ready}, 32'd1);
      chk("abort_cap no rsp", {31'b0, rsp_valid}, 32'd0);
      run('{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hAB00_000A, 1'b0, 3, 32'h0}, 100);
      // word store aborted by reset during WR
      @(negedge clk);
      req_valid = 1'b1;
      req_we = 1'b1;
      req_size = 2'b10;
      req_addr = 32'h0C;
      req_wdata = 32'h1111_1111;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("abort_wr mem_write", {31'b0, mem_write}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_wr mem_write drop", {31'b0, mem_write}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      run('{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0, 32'hAB00_000A, 1'b0, 3, 32'h0}, 101);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
